// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 constants and FSM state type for the data-memory responder
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - load lane extract/extend, store lane shift/byte-enable, misalignment detect
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic        is_write,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] load_data,
    output logic [3:0]  store_be,
    output logic [31:0] store_data,
    output logic        misaligned,
    output logic        bad_funct3
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0 for loads and up into its lane for stores,
    // then decode access size, extension and alignment from funct3.
    always_comb begin
        shifted    = rword >> {byte_off, 3'b000};
        store_data = wdata << {byte_off, 3'b000};
        load_data  = 32'h0;
        store_be   = 4'b0000;
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        if (is_write) begin
            case (funct3)
                F3_SB: store_be = 4'b0001 << byte_off;
                F3_SH: begin
                    store_be   = 4'b0011 << byte_off;
                    misaligned = byte_off[0];
                end
                F3_SW: begin
                    store_be   = 4'b1111;
                    misaligned = |byte_off;
                end
                default: bad_funct3 = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                F3_LH: begin
                    load_data  = {{16{shifted[15]}}, shifted[15:0]};
                    misaligned = byte_off[0];
                end
                F3_LW: begin
                    load_data  = rword;
                    misaligned = |byte_off;
                end
                F3_LBU: load_data = {24'h0, shifted[7:0]};
                F3_LHU: begin
                    load_data  = {16'h0, shifted[15:0]};
                    misaligned = byte_off[0];
                end
                default: bad_funct3 = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed wait latency
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [31:0] mem [0:DEPTH_WORDS-1];
    logic [31:0] rword;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic        misaligned;
    logic        bad_funct3;
    logic        out_of_range;
    logic        req_err;
    logic        accept;
    logic        enter_resp;
    logic        mem_we;
    logic [IDX_W-1:0] mem_idx;

    assign accept       = req_valid && (state_q == ST_IDLE);
    // The response edge is the one leaving WAIT; all memory effects happen there.
    assign enter_resp   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign out_of_range = {2'b00, addr_q[31:2]} >= DEPTH_WORDS;
    assign req_err      = misaligned || bad_funct3 || out_of_range;
    assign mem_we       = enter_resp && write_q && !req_err;
    assign mem_idx      = addr_q[IDX_W+1:2];
    assign rword        = mem[mem_idx];

    mem_lane_align u_align (
        .is_write   (write_q),
        .byte_off   (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .rword      (rword),
        .load_data  (load_data),
        .store_be   (store_be),
        .store_data (store_data),
        .misaligned (misaligned),
        .bad_funct3 (bad_funct3)
    );

    // State and datapath registers; reset clears the pending request and any response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Next-state: accept only in IDLE, count out the wait, release on response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from state.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rdata_q;
        rsp_error = error_q;
    end

    // Request latch and wait counter; inputs are only sampled when accepted.
    always_comb begin
        write_d  = write_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        if (accept) begin
            write_d  = req_write;
            addr_d   = req_addr;
            funct3_d = req_funct3;
            wdata_d  = req_wdata;
            cnt_d    = 4'(WAIT_CYCLES);
        end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Response capture on entry to RESP; cleared once the core takes it.
    always_comb begin
        rdata_d = rdata_q;
        error_d = error_q;
        if (enter_resp) begin
            rdata_d = (write_q || req_err) ? 32'h0 : load_data;
            error_d = req_err;
        end else if (state_q == ST_RESP && rsp_ready) begin
            rdata_d = 32'h0;
            error_d = 1'b0;
        end
    end

    // Byte-lane store commit; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (store_be[i]) mem[mem_idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst1_n, rst3_n, sel;
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;

    logic        rr1, rv1, re1, rr3, rv3, re3;
    logic [31:0] rd1, rd3;
    logic        o_req_ready, o_rsp_valid, o_rsp_error;
    logic [31:0] o_rsp_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst1_n),
        .req_valid(req_valid && !sel), .req_ready(rr1),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_ready(rsp_ready && !sel), .rsp_rdata(rd1), .rsp_error(re1)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst3_n),
        .req_valid(req_valid && sel), .req_ready(rr3),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_ready(rsp_ready && sel), .rsp_rdata(rd3), .rsp_error(re3)
    );

    assign o_req_ready = sel ? rr3 : rr1;
    assign o_rsp_valid = sel ? rv3 : rv1;
    assign o_rsp_rdata = sel ? rd3 : rd1;
    assign o_rsp_error = sel ? re3 : re1;

    // Byte-addressed reference memory
    logic [7:0] model_mem [0:DEPTH*4-1];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  f3;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic void model(input logic w, input logic [31:0] a, input logic [2:0] f3,
                                  input logic [31:0] d, output logic [31:0] rd, output logic er);
        logic illegal;
        int n;
        logic [31:0] v;
        illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        n  = 1 << f3[1:0];
        er = illegal || ((a % n) != 0) || ((a / 4) >= DEPTH);
        rd = 32'h0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < n; i++) model_mem[a + i] = d[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(model_mem[a + i]) << (8*i));
                if (f3 < 3'd4 && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
                rd = v;
            end
        end
    endfunction

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        check("req_ready_before_txn", 32'(o_req_ready), 32'd1);
        req_write = w; req_addr = a; req_funct3 = f3; req_wdata = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!o_rsp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = o_rsp_rdata;
        er = o_rsp_error;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, erd, hold_rd;
        logic        er, eer, w;
        logic [31:0] a, d;
        logic [2:0]  f3;
        int          lat, r, wait_n;

        tbl[0]  = '{1'b1, 32'h10,   3'b010, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 32'h13,   3'b000, 32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[3]  = '{1'b0, 32'h13,   3'b100, 32'h0,        32'h000000DE, 1'b0};
        tbl[4]  = '{1'b0, 32'h12,   3'b001, 32'h0,        32'hFFFFDEAD, 1'b0};
        tbl[5]  = '{1'b0, 32'h10,   3'b101, 32'h0,        32'h0000BEEF, 1'b0};
        tbl[6]  = '{1'b1, 32'h11,   3'b000, 32'h00000055, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEAD55EF, 1'b0};
        tbl[8]  = '{1'b0, 32'h12,   3'b010, 32'h0,        32'h0,        1'b1};
        tbl[9]  = '{1'b1, 32'h11,   3'b001, 32'h0000FFFF, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 32'h1000, 3'b010, 32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b1, 32'h1000, 3'b010, 32'h11111111, 32'h0,        1'b1};
        tbl[12] = '{1'b0, 32'h10,   3'b011, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{1'b1, 32'h10,   3'b100, 32'h22222222, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEAD55EF, 1'b0};

        sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_funct3 = 3'b000; req_wdata = 32'h0; rsp_ready = 1'b0;
        rst1_n = 1'b0; rst3_n = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            check($sformatf("reset_req_ready[%0d]", s), 32'(o_req_ready), 32'd1);
            check($sformatf("reset_rsp_valid[%0d]", s), 32'(o_rsp_valid), 32'd0);
            check($sformatf("reset_rsp_rdata[%0d]", s), o_rsp_rdata, 32'd0);
            check($sformatf("reset_rsp_error[%0d]", s), 32'(o_rsp_error), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1; rst3_n = 1'b1;

        // Directed table on the WAIT_CYCLES=1 instance
        for (int i = 0; i < 15; i++) begin
            do_txn(tbl[i].w, tbl[i].a, tbl[i].f3, tbl[i].d, rd, er, lat);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_error", i), 32'(er), 32'(tbl[i].exp_er));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
        end

        // Response held while core stalls; a store presented meanwhile must be ignored
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_write = 1'b1; req_wdata = 32'h0;
        wait_n = 0;
        while (!o_rsp_valid && wait_n < 64) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("stall_latency", 32'(wait_n), 32'd2);
        hold_rd = o_rsp_rdata;
        check("stall_rdata_first", hold_rd, 32'hDEAD55EF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_rsp_valid", c), 32'(o_rsp_valid), 32'd1);
            check($sformatf("stall%0d_rdata", c), o_rsp_rdata, 32'hDEAD55EF);
            check($sformatf("stall%0d_req_ready", c), 32'(o_req_ready), 32'd0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stall_release_req_ready", 32'(o_req_ready), 32'd1);
        check("stall_release_rsp_valid", 32'(o_rsp_valid), 32'd0);
        do_txn(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        check("stall_store_ignored", rd, 32'hDEAD55EF);

        // Randomised traffic against the reference model
        for (int wi = 0; wi < 16; wi++) begin
            d = $urandom;
            model(1'b1, 32'(wi * 4), 3'b010, d, erd, eer);
            do_txn(1'b1, 32'(wi * 4), 3'b010, d, rd, er, lat);
            check($sformatf("preload%0d_error", wi), 32'(er), 32'(eer));
        end
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h1000 + $urandom_range(0, 63);
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = $urandom_range(0, 63);
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            model(w, a, f3, d, erd, eer);
            do_txn(w, a, f3, d, rd, er, lat);
            check($sformatf("rnd%0d_rdata w=%0d a=%h f3=%0d", k, w, a, f3), rd, erd);
            check($sformatf("rnd%0d_error", k), 32'(er), 32'(eer));
            check($sformatf("rnd%0d_latency", k), 32'(lat), 32'd2);
        end

        // WAIT_CYCLES=3 instance: reset during WAIT drops the store
        sel = 1'b1;
        do_txn(1'b1, 32'h20, 3'b010, 32'hA5A5A5A5, rd, er, lat);
        check("w3_preload_latency", 32'(lat), 32'd4);
        check("w3_preload_error", 32'(er), 32'd0);
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("w3_in_wait_req_ready", 32'(o_req_ready), 32'd0);
        rst3_n = 1'b0; #1;
        check("w3_rst_req_ready", 32'(o_req_ready), 32'd1);
        check("w3_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("w3_rst_rsp_rdata", o_rsp_rdata, 32'd0);
        check("w3_rst_rsp_error", 32'(o_rsp_error), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        do_txn(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        check("w3_after_reset_rdata", rd, 32'hA5A5A5A5);
        check("w3_after_reset_latency", 32'(lat), 32'd4);

        // Reset during RESP discards the pending response
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h20; req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_n = 0;
        while (!o_rsp_valid && wait_n < 64) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("w3_resp_reached", 32'(o_rsp_valid), 32'd1);
        rst3_n = 1'b0; #1;
        check("w3_resp_rst_valid", 32'(o_rsp_valid), 32'd0);
        check("w3_resp_rst_rdata", o_rsp_rdata, 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        do_txn(1'b0, 32'h22, 3'b101, 32'h0, rd, er, lat);
        check("w3_final_lhu", rd, 32'h0000A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
